// File: rtl/led_row_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_row_rx_ctrl_if
//
// This interface carries the 8-bit receive AXI-stream from the MAC frame FIFO
// into the LED row sequencer.
//
//   rx_axis_tdata   received byte
//   rx_axis_tvalid  byte valid
//   rx_axis_tready  byte accepted (driven by the sequencer)
//   rx_axis_tlast   last byte of the frame
//   rx_axis_tuser   bad frame (FCS error), meaningful only together with tlast
//
// Modports:
//   master  the stream source (MAC / frame FIFO)
//   slave   the stream sink (led_row_rx_ctrl)
// ---------------------------------------------------------------------------
interface led_row_rx_ctrl_if;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid;
  logic       rx_axis_tready;
  logic       rx_axis_tlast;
  logic       rx_axis_tuser;

  modport master (
    output rx_axis_tdata,
    output rx_axis_tvalid,
    output rx_axis_tlast,
    output rx_axis_tuser,
    input  rx_axis_tready
  );

  modport slave (
    input  rx_axis_tdata,
    input  rx_axis_tvalid,
    input  rx_axis_tlast,
    input  rx_axis_tuser,
    output rx_axis_tready
  );
endinterface

// File: rtl/led_row_rx_ctrl.sv
// ---------------------------------------------------------------------------
// led_row_rx_ctrl
//
// This block is the receive-side sequencer between the MAC RX stream and a
// double-banked LED framebuffer. It parses each Ethernet frame and checks the
// destination MAC (LOCAL_MAC or broadcast), the EtherType and the row index.
// It writes one row of pixel bytes into the back bank. When a good frame
// carries flags bit0, it swaps the front and back banks. It also counts good
// frames and dropped frames.
//
// Frame layout (byte offsets):
//   0-5 dest MAC, 6-11 src MAC, 12-13 EtherType, 14 flags, 15 row,
//   16.. ROW_BYTES pixel bytes, then optional padding.
//
// Ports:
//   clk_125      system clock
//   rst_n        asynchronous active-low reset
//   rx           receive AXI-stream (slave side)
//   fb_wr_en     framebuffer byte write strobe
//   fb_wr_addr   {back_bank, row, byte_idx}
//   fb_wr_data   pixel byte
//   front_bank   bank currently displayed
//   swap_pulse   one-cycle strobe on bank swap
//   good_count   good frames committed (wraps)
//   drop_count   frames dropped (wraps)
// ---------------------------------------------------------------------------
module led_row_rx_ctrl #(
  parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          MATRIX_HEIGHT = 32,
  parameter int          ROW_BYTES     = 192,
  parameter int          ROW_AW        = 5,
  parameter int          COL_AW        = 8
) (
  input  logic                     clk_125,
  input  logic                     rst_n,
  led_row_rx_ctrl_if.slave         rx,
  output logic                     fb_wr_en,
  output logic [ROW_AW+COL_AW:0]   fb_wr_addr,
  output logic [7:0]               fb_wr_data,
  output logic                     front_bank,
  output logic                     swap_pulse,
  output logic [15:0]              good_count,
  output logic [15:0]              drop_count
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PIX   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0]        ROW_LIMIT = 8'(MATRIX_HEIGHT);
  localparam logic [COL_AW-1:0] LAST_COL  = COL_AW'(ROW_BYTES - 1);

  state_t            state;
  logic [3:0]        hdr_cnt;     // header byte offset, 0..15
  logic [COL_AW-1:0] col_idx;     // pixel byte index within the row
  logic [ROW_AW-1:0] row;
  logic              ucast_ok;    // dest bytes so far match LOCAL_MAC
  logic              bcast_ok;    // dest bytes so far are all 0xFF
  logic              swap_flag;
  logic              row_done;    // all pixel bytes written, padding follows

  logic              accept;
  logic              ucast_nxt;
  logic              bcast_nxt;
  logic              hdr_fail;
  logic              frame_good;

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    return LOCAL_MAC[8*(5 - 32'(idx)) +: 8];
  endfunction

  assign accept = rx.rx_axis_tvalid & rx.rx_axis_tready;

  // Each header byte is checked as it arrives. A bad frame goes to DRAIN
  // at the first byte that fails.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ucast_nxt = ucast_ok & (rx.rx_axis_tdata == mac_byte(hdr_cnt[2:0]));
    bcast_nxt = bcast_ok & (rx.rx_axis_tdata == 8'hFF);
    hdr_fail  = 1'b0;
    case (hdr_cnt)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: hdr_fail = ~(ucast_nxt | bcast_nxt);
      4'd12:   hdr_fail = (rx.rx_axis_tdata != ETHERTYPE[15:8]);
      4'd13:   hdr_fail = (rx.rx_axis_tdata != ETHERTYPE[7:0]);
      4'd15:   hdr_fail = (rx.rx_axis_tdata >= ROW_LIMIT);
      default: hdr_fail = 1'b0;
    endcase
  end

  // Decided on the tlast byte. A frame is good only if it delivered every
  // pixel byte and has a clean FCS. HDR never reaches row_done, so a runt
  // or a rejected header always counts as a drop.
  always_comb begin
    frame_good = 1'b0;
    if (!rx.rx_axis_tuser) begin
      if (state == PIX)   frame_good = (col_idx == LAST_COL);
      if (state == DRAIN) frame_good = row_done;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops,
  // including the write-port outputs, come out of reset with defined values.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HDR;
      hdr_cnt          <= '0;
      col_idx          <= '0;
      row              <= '0;
      ucast_ok         <= 1'b1;
      bcast_ok         <= 1'b1;
      swap_flag        <= 1'b0;
      row_done         <= 1'b0;
      rx.rx_axis_tready <= 1'b0;
      fb_wr_en         <= 1'b0;
      fb_wr_addr       <= '0;
      fb_wr_data       <= '0;
      front_bank       <= 1'b0;
      swap_pulse       <= 1'b0;
      good_count       <= '0;
      drop_count       <= '0;
    end else begin
      rx.rx_axis_tready <= 1'b1;
      fb_wr_en         <= 1'b0;
      swap_pulse       <= 1'b0;

      if (accept) begin
        unique case (state)
          HDR: begin
            if (hdr_cnt <= 4'd5) begin
              ucast_ok <= ucast_nxt;
              bcast_ok <= bcast_nxt;
            end
            if (hdr_cnt == 4'd14) swap_flag <= rx.rx_axis_tdata[0];
            if (hdr_cnt == 4'd15) row <= rx.rx_axis_tdata[ROW_AW-1:0];

            if (hdr_fail)               state   <= DRAIN;
            else if (hdr_cnt == 4'd15)  state   <= PIX;
            else                        hdr_cnt <= hdr_cnt + 4'd1;
          end

          PIX: begin
            // Use the back bank as it stands now. A swap by this same frame
            // takes effect at this edge, so it only affects later frames.
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= {~front_bank, row, col_idx};
            fb_wr_data <= rx.rx_axis_tdata;
            if (col_idx == LAST_COL) begin
              state    <= DRAIN;
              row_done <= 1'b1;
            end else begin
              col_idx <= col_idx + COL_AW'(1);
            end
          end

          DRAIN: ;

          default: state <= HDR;
        endcase

        // Frame end. These assignments come after the case, so they
        // override the state and counter updates above.
        if (rx.rx_axis_tlast) begin
          state    <= HDR;
          hdr_cnt  <= '0;
          col_idx  <= '0;
          ucast_ok <= 1'b1;
          bcast_ok <= 1'b1;
          row_done <= 1'b0;
          if (frame_good) begin
            good_count <= good_count + 16'd1;
            if (swap_flag) begin
              front_bank <= ~front_bank;
              swap_pulse <= 1'b1;
            end
          end else begin
            drop_count <= drop_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_row_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_row_rx_ctrl
//
// Directed testbench for led_row_rx_ctrl. It builds frames byte by byte and
// drives them on the falling edge. A monitor collects framebuffer writes,
// swap pulses and tready lows on the falling edge. After each frame it
// compares them with the expected values computed by hand.
// ---------------------------------------------------------------------------
module tb_led_row_rx_ctrl;

  typedef logic [7:0] bq_t[$];

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;

  logic        clk_125 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        fb_wr_en;
  logic [13:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        front_bank;
  logic        swap_pulse;
  logic [15:0] good_count;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          swap_cnt  = 0;
  int          tready_lo = 0;
  bit          tr_mon    = 1'b0;

  led_row_rx_ctrl_if rx_if ();

  led_row_rx_ctrl dut (
    .clk_125    (clk_125),
    .rst_n      (rst_n),
    .rx         (rx_if.slave),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .front_bank (front_bank),
    .swap_pulse (swap_pulse),
    .good_count (good_count),
    .drop_count (drop_count)
  );

  always #4 clk_125 = ~clk_125;

  always @(negedge clk_125) begin
    if (fb_wr_en) begin
      wr_addr_q.push_back(fb_wr_addr);
      wr_data_q.push_back(fb_wr_data);
    end
    if (swap_pulse) swap_cnt++;
    if (tr_mon && !rx_if.rx_axis_tready) tready_lo++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bq_t build(input logic [47:0] dest, input logic [15:0] et,
                                input logic [7:0] flags, input logic [7:0] row,
                                input int npix, input int npad, input logic [7:0] xv);
    bq_t f;
    for (int i = 0; i < 6; i++) f.push_back(dest[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h10 + 8'(i));
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    f.push_back(flags);
    f.push_back(row);
    for (int i = 0; i < npix; i++) f.push_back(8'(i) ^ xv);
    for (int i = 0; i < npad; i++) f.push_back(8'hEE);
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_125);
      rx_if.rx_axis_tvalid = 1'b0;
      rx_if.rx_axis_tlast  = 1'b0;
      rx_if.rx_axis_tuser  = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    @(negedge clk_125);
    rx_if.rx_axis_tdata  = d;
    rx_if.rx_axis_tvalid = 1'b1;
    rx_if.rx_axis_tlast  = last;
    rx_if.rx_axis_tuser  = user;
    while (!rx_if.rx_axis_tready && n < 50) begin
      @(negedge clk_125);
      n++;
    end
    if (n >= 50) check("tready_timeout", 32'(n), 32'd0);
    @(posedge clk_125);
  endtask

  task automatic send_frame(input bq_t f, input logic user, input bit gaps);
    for (int i = 0; i < f.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) idle(1);
      end
      send_byte(f[i], (i == f.size() - 1), user && (i == f.size() - 1));
    end
    idle(3);
  endtask

  task automatic check_writes(input string tag, input logic bank, input int row,
                              input int n, input logic [7:0] xv);
    int          bad = 0;
    logic [13:0] ea;
    check({tag, " wr_count"}, 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      ea = {bank, 5'(row), 8'(i)};
      if (wr_addr_q[i] !== ea || wr_data_q[i] !== (8'(i) ^ xv)) bad++;
    end
    check({tag, " wr_content"}, 32'(bad), 32'd0);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_state(input string tag, input int good, input int drop,
                             input logic front, input int swaps);
    check({tag, " good_count"}, 32'(good_count), 32'(good));
    check({tag, " drop_count"}, 32'(drop_count), 32'(drop));
    check({tag, " front_bank"}, 32'(front_bank), 32'(front));
    check({tag, " swaps"},      32'(swap_cnt),   32'(swaps));
    swap_cnt = 0;
  endtask

  initial begin
    bq_t f;
    rx_if.rx_axis_tdata  = 8'h00;
    rx_if.rx_axis_tvalid = 1'b0;
    rx_if.rx_axis_tlast  = 1'b0;
    rx_if.rx_axis_tuser  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_125);
    check("rst tready",     32'(rx_if.rx_axis_tready), 32'd0);
    check("rst fb_wr_en",   32'(fb_wr_en),   32'd0);
    check("rst fb_wr_addr", 32'(fb_wr_addr), 32'd0);
    check("rst fb_wr_data", 32'(fb_wr_data), 32'd0);
    check("rst front_bank", 32'(front_bank), 32'd0);
    check("rst swap_pulse", 32'(swap_pulse), 32'd0);
    check("rst good_count", 32'(good_count), 32'd0);
    check("rst drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Good unicast frame, row 5, no swap
    send_frame(build(LOCAL_MAC, 16'h88B5, 8'h00, 8'd5, 192, 0, 8'h00), 1'b0, 1'b0);
    check_writes("ucast", 1'b1, 5, 192, 8'h00);
    check_state("ucast", 1, 0, 1'b0, 0);

    // Good broadcast frame, row 31, with swap
    send_frame(build(BCAST, 16'h88B5, 8'h01, 8'd31, 192, 0, 8'hA5), 1'b0, 1'b0);
    check_writes("bcast", 1'b1, 31, 192, 8'hA5);
    check_state("bcast", 2, 0, 1'b1, 1);

    // After the swap, row 0 lands in bank 0
    send_frame(build(LOCAL_MAC, 16'h88B5, 8'h00, 8'd0, 192, 0, 8'h3C), 1'b0, 1'b0);
    check_writes("post_swap", 1'b0, 0, 192, 8'h3C);
    check_state("post_swap", 3, 0, 1'b1, 0);

    // Rejected headers: EtherType, row out of range, foreign dest
    send_frame(build(LOCAL_MAC, 16'h0800, 8'h01, 8'd1, 192, 0, 8'h00), 1'b0, 1'b0);
    send_frame(build(LOCAL_MAC, 16'h88B5, 8'h01, 8'd32, 192, 0, 8'h00), 1'b0, 1'b0);
    send_frame(build(OTHER_MAC, 16'h88B5, 8'h01, 8'd2, 192, 0, 8'h00), 1'b0, 1'b0);
    check_writes("reject", 1'b0, 0, 0, 8'h00);
    check_state("reject", 3, 3, 1'b1, 0);

    // Short frame: tlast on pixel byte 100
    send_frame(build(LOCAL_MAC, 16'h88B5, 8'h01, 8'd9, 100, 0, 8'h00), 1'b0, 1'b0);
    check_writes("short", 1'b0, 9, 100, 8'h00);
    check_state("short", 3, 4, 1'b1, 0);

    // Full frame with bad FCS and swap flag
    send_frame(build(LOCAL_MAC, 16'h88B5, 8'h01, 8'd12, 192, 0, 8'h5A), 1'b1, 1'b0);
    check_writes("bad_fcs", 1'b0, 12, 192, 8'h5A);
    check_state("bad_fcs", 3, 5, 1'b1, 0);

    // 10-byte runt
    f = build(LOCAL_MAC, 16'h88B5, 8'h00, 8'd3, 0, 0, 8'h00);
    while (f.size() > 10) void'(f.pop_back());
    send_frame(f, 1'b0, 1'b0);
    check_writes("runt", 1'b0, 0, 0, 8'h00);
    check_state("runt", 3, 6, 1'b1, 0);

    // Random tvalid gaps and 20 pad bytes
    tr_mon = 1'b1;
    send_frame(build(BCAST, 16'h88B5, 8'h00, 8'd10, 192, 20, 8'hC3), 1'b0, 1'b1);
    tr_mon = 1'b0;
    check_writes("gaps", 1'b0, 10, 192, 8'hC3);
    check_state("gaps", 4, 6, 1'b1, 0);
    check("gaps tready_low", 32'(tready_lo), 32'd0);

    // Reset in the middle of pixel byte 50
    f = build(LOCAL_MAC, 16'h88B5, 8'h01, 8'd20, 192, 0, 8'h00);
    for (int i = 0; i < 66; i++) send_byte(f[i], 1'b0, 1'b0);
    @(negedge clk_125);
    check("midrst wr_en_before", 32'(fb_wr_en), 32'd1);
    rst_n = 1'b0;
    rx_if.rx_axis_tvalid = 1'b0;
    #1;
    check("midrst fb_wr_en",   32'(fb_wr_en),   32'd0);
    check("midrst good_count", 32'(good_count), 32'd0);
    check("midrst drop_count", 32'(drop_count), 32'd0);
    check("midrst front_bank", 32'(front_bank), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    wr_addr_q.delete();
    wr_data_q.delete();
    swap_cnt = 0;

    // Fresh frame after the reset is released
    send_frame(build(LOCAL_MAC, 16'h88B5, 8'h00, 8'd7, 192, 0, 8'h00), 1'b0, 1'b0);
    check_writes("after_rst", 1'b1, 7, 192, 8'h00);
    check_state("after_rst", 1, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
